max7219_spi_responder: RTL

// - MAX7219-compatible SPI receiver: captures 16-bit {addr,data} frames on spi_clk/din/cs, latches them on cs rise.
// - Holds the MAX7219 register file and drives a per-digit segment image; the on-FPGA display end of the max7219 driver link.
// - Also serves as a loopback checker for the display driver on the bench.

---
 rtl/max7219_pkg.sv | 26 ++
 rtl/max7219_codeb_font.sv | 29 ++
 rtl/max7219_spi_responder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/max7219_pkg.sv
// Shared register map, frame constants and frame FSM states for the MAX7219 SPI responder.
package max7219_pkg;

    localparam logic [3:0] REG_NOP          = 4'h0;
    localparam logic [3:0] REG_DIGIT0       = 4'h1;
    localparam logic [3:0] REG_DIGIT1       = 4'h2;
    localparam logic [3:0] REG_DIGIT2       = 4'h3;
    localparam logic [3:0] REG_DIGIT3       = 4'h4;
    localparam logic [3:0] REG_DIGIT4       = 4'h5;
    localparam logic [3:0] REG_DIGIT5       = 4'h6;
    localparam logic [3:0] REG_DIGIT6       = 4'h7;
    localparam logic [3:0] REG_DIGIT7       = 4'h8;
    localparam logic [3:0] REG_DECODE_MODE  = 4'h9;
    localparam logic [3:0] REG_INTENSITY    = 4'hA;
    localparam logic [3:0] REG_SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN     = 4'hC;
    localparam logic [3:0] REG_DISPLAY_TEST = 4'hF;

    localparam int unsigned FRAME_BITS = 16;

    typedef enum logic {
        IDLE,
        SHIFT
    } frame_state_t;

endpackage

// File: rtl/max7219_codeb_font.sv
// Code-B font: 4-bit code to segments A..G (bit 6 = A, bit 0 = G), decimal point excluded.
module max7219_codeb_font (
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h00;
        case (code_i)
            4'h0: seg_o = 7'h7E;
            4'h1: seg_o = 7'h30;
            4'h2: seg_o = 7'h6D;
            4'h3: seg_o = 7'h79;
            4'h4: seg_o = 7'h33;
            4'h5: seg_o = 7'h5B;
            4'h6: seg_o = 7'h5F;
            4'h7: seg_o = 7'h70;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h7B;
            4'hA: seg_o = 7'h01;
            4'hB: seg_o = 7'h4F;
            4'hC: seg_o = 7'h37;
            4'hD: seg_o = 7'h0E;
            4'hE: seg_o = 7'h67;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/max7219_spi_responder.sv
// MAX7219-compatible SPI receiver, register file and segment image driver.
// Define MAX7219_CODEB_EN to enable Code-B decoding of digits selected by decode_mode.
module max7219_spi_responder
    import max7219_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ERR_ON_LONG = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_clk_i,
    input  logic        din_i,
    input  logic        cs_i,
    output logic        wr_valid_o,
    output logic [3:0]  wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic        frame_err_o,
    output logic [7:0]  decode_mode_o,
    output logic [3:0]  intensity_o,
    output logic [2:0]  scan_limit_o,
    output logic        shutdown_n_o,
    output logic        display_test_o,
    output logic [63:0] seg_o
);

    logic [SYNC_STAGES-1:0] spi_clk_sync_q, din_sync_q, cs_sync_q;
    logic                   spi_clk_prev_q, cs_prev_q;
    logic                   spi_rise, cs_rise, cs_fall, cs_s;

    frame_state_t state_q, state_d;
    // Bits [15:12] of a frame are don't-care, so only the low 12 bits are kept.
    logic [11:0]  shreg_q, shreg_d;
    logic [4:0]   count_q, count_d;
    logic         wr_valid_q, wr_valid_d, frame_err_q, frame_err_d;
    logic [3:0]   wr_addr_q, wr_addr_d, intensity_q, intensity_d;
    logic [7:0]   wr_data_q, wr_data_d, decode_mode_q, decode_mode_d;
    logic [2:0]   scan_limit_q, scan_limit_d;
    logic         shutdown_n_q, shutdown_n_d, display_test_q, display_test_d;
    logic [7:0]   digit_q [8];
    logic [7:0]   digit_d [8];
    logic [7:0]   image [8];
    logic [3:0]   frame_addr;
    logic [7:0]   frame_data;

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign spi_rise = spi_clk_sync_q[SYNC_STAGES-1] & ~spi_clk_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;

    assign frame_addr = shreg_q[11:8];
    assign frame_data = shreg_q[7:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            spi_clk_sync_q <= '0;
            din_sync_q     <= '0;
            cs_sync_q      <= '1;
            spi_clk_prev_q <= 1'b0;
            cs_prev_q      <= 1'b1;
        end else begin
            spi_clk_sync_q <= {spi_clk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
            din_sync_q     <= {din_sync_q[SYNC_STAGES-2:0], din_i};
            cs_sync_q      <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
            spi_clk_prev_q <= spi_clk_sync_q[SYNC_STAGES-1];
            cs_prev_q      <= cs_s;
        end
    end

    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        count_d        = count_q;
        wr_valid_d     = 1'b0;
        frame_err_d    = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        decode_mode_d  = decode_mode_q;
        intensity_d    = intensity_q;
        scan_limit_d   = scan_limit_q;
        shutdown_n_d   = shutdown_n_q;
        display_test_d = display_test_q;
        digit_d        = digit_q;

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    count_d = 5'd0;
                end
            end
            SHIFT: begin
                // A cs rise wins over a coincident spi_clk rise.
                if (cs_rise) begin
                    state_d = IDLE;
                    if (count_q >= 5'(FRAME_BITS)) begin
                        wr_valid_d  = 1'b1;
                        wr_addr_d   = frame_addr;
                        wr_data_d   = frame_data;
                        frame_err_d = (ERR_ON_LONG != 0) && (count_q > 5'(FRAME_BITS));
                        if (frame_addr >= REG_DIGIT0 && frame_addr <= REG_DIGIT7) begin
                            digit_d[3'(frame_addr - REG_DIGIT0)] = frame_data;
                        end
                        case (frame_addr)
                            REG_DECODE_MODE:  decode_mode_d  = frame_data;
                            REG_INTENSITY:    intensity_d    = frame_data[3:0];
                            REG_SCAN_LIMIT:   scan_limit_d   = frame_data[2:0];
                            REG_SHUTDOWN:     shutdown_n_d   = frame_data[0];
                            REG_DISPLAY_TEST: display_test_d = frame_data[0];
                            default: ;
                        endcase
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (spi_rise) begin
                    shreg_d = {shreg_q[10:0], din_sync_q[SYNC_STAGES-1]};
                    if (count_q != 5'd31) begin
                        count_d = count_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            count_q        <= '0;
            wr_valid_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            decode_mode_q  <= '0;
            intensity_q    <= '0;
            scan_limit_q   <= '0;
            shutdown_n_q   <= 1'b0;
            display_test_q <= 1'b0;
            digit_q        <= '{default: '0};
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            count_q        <= count_d;
            wr_valid_q     <= wr_valid_d;
            frame_err_q    <= frame_err_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            decode_mode_q  <= decode_mode_d;
            intensity_q    <= intensity_d;
            scan_limit_q   <= scan_limit_d;
            shutdown_n_q   <= shutdown_n_d;
            display_test_q <= display_test_d;
            digit_q        <= digit_d;
        end
    end

`ifdef MAX7219_CODEB_EN
    for (genvar g = 0; g < 8; g++) begin : g_codeb
        logic [6:0] font;
        max7219_codeb_font u_font (
            .code_i (digit_q[g][3:0]),
            .seg_o  (font)
        );
        assign image[g] = decode_mode_q[g] ? {digit_q[g][7], font} : digit_q[g];
    end
`else
    assign image = digit_q;
`endif

    always_comb begin
        seg_o = '0;
        for (int i = 0; i < 8; i++) begin
            if (display_test_q) begin
                seg_o[8*i +: 8] = 8'hFF;
            end else if (shutdown_n_q && (3'(i) <= scan_limit_q)) begin
                seg_o[8*i +: 8] = image[i];
            end
        end
    end

    assign wr_valid_o     = wr_valid_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
    assign frame_err_o    = frame_err_q;
    assign decode_mode_o  = decode_mode_q;
    assign intensity_o    = intensity_q;
    assign scan_limit_o   = scan_limit_q;
    assign shutdown_n_o   = shutdown_n_q;
    assign display_test_o = display_test_q;

endmodule
